iic_slave: RTL
==============

IIC_SLAVE -- requirements
Module: iic_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit bus address this device answers to.
REQ-002 SHALL have parameter REG_DEPTH, default 16, the number of 8-bit registers in the internal register file (power of two, 2..256).
REQ-003 SHALL have port sys_clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IICSCL  input  1  bus clock from the master.
REQ-006 SHALL have port IICSDA  inout  1  open-drain data line; driven 0 or released to 'z', never driven 1.
REQ-007 SHALL have port RegWrValid  output  1  one-cycle strobe, one register write committed.
REQ-008 SHALL have port RegWrAddr  output  8  register index of the committed write.
REQ-009 SHALL have port RegWrData  output  8  data of the committed write.
REQ-010 SHALL have port Busy  output  1  high from an addressed START until STOP or NACK release.

Function
REQ-011 SHALL synchronise IICSCL and IICSDA with 2 flops each and detect SCL rise/fall from the synchronised samples.
REQ-012 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-013 SHALL use states IDLE, DEVADDR, DEVACK, REGADDR, REGACK, WDATA, WDACK, RDATA, RDACK.
REQ-014 SHALL enter DEVADDR on any START (including a repeated START) from any state, and IDLE on any STOP from any state.
REQ-015 SHALL shift in data MSB first on SCL rise, and drive or release SDA only on the cycle after an SCL fall.
REQ-016 SHALL, on address match after 8 bits, hold SDA low for the 9th clock (DEVACK); on mismatch SHALL release SDA and go to IDLE.
REQ-017 SHALL, with R/W=0, go DEVACK->REGADDR, ACK the register address byte (REGACK), load the pointer, then loop WDATA/WDACK.
REQ-018 SHALL, in WDACK, write regfile[pointer mod REG_DEPTH] and pulse RegWrValid for exactly one sys_clk with RegWrAddr=pointer and RegWrData=byte.
REQ-019 SHALL, with R/W=1, go DEVACK->RDATA, shifting out regfile[pointer mod REG_DEPTH] MSB first, with bit 7 presented after the ACK-ending SCL fall.
REQ-020 SHALL, in RDACK, sample the master's bit on SCL rise: 0 (ACK) -> next byte in RDATA; 1 (NACK) -> release SDA, go to IDLE, clear Busy.
REQ-021 SHALL preserve the pointer across repeated START, so write-register-address then repeated-START read returns that register.
REQ-022 SHALL ignore SDA changes while SCL is high other than START and STOP; a STOP mid-byte SHALL discard the partial byte without a write.
REQ-023 SHALL produce an 8-bit pointer that wraps 8'hFF -> 8'h00.

Reset
REQ-024 SHALL asynchronously, on rst_n low, force state IDLE, SDA released, RegWrValid=0, RegWrAddr=0, RegWrData=0, Busy=0, pointer=0, and all registers 8'h00.
REQ-025 SHALL, on reset asserted mid-transfer, release SDA in the same instant and ignore the bus until the next START after rst_n rises.

Configuration
REQ-026 SHALL, with macro IIC_SLAVE_AUTOINC_EN defined, increment the pointer after every ACKed written byte and after every byte read.
REQ-027 SHALL, without IIC_SLAVE_AUTOINC_EN, keep the pointer fixed, so multi-byte writes overwrite one register and multi-byte reads repeat it.

Structure
REQ-028 SHALL define the state enumeration, the default SLAVE_ADDR and the R/W bit encoding in shared package iic_pkg.
REQ-029 SHALL place synchroniser, edge and START/STOP detection in sub-module iic_bus_sync; FSM, shifter and regfile stay in iic_slave.

Verification
REQ-030 SHALL cover write: START, 0xA0, 0x03, 0x5A, STOP -> three ACKs, one RegWrValid with Addr=0x03 Data=0x5A, and regfile[3]=0x5A.
REQ-031 SHALL cover read: START 0xA0 0x03, repeated START 0xA1, read, NACK, STOP -> byte 0x5A on SDA, SDA released after NACK, Busy=0.
REQ-032 SHALL cover mismatch: START, 0xB0 -> no ACK (SDA high in 9th clock), no RegWrValid, Busy stays 0.
REQ-033 SHALL cover burst (AUTOINC on): write 0x0F then 0x11,0x22 -> regfile[15]=0x11, regfile[0]=0x22 (REG_DEPTH=16 wrap); AUTOINC off -> regfile[15]=0x22.
REQ-034 SHALL cover aborts: STOP after 4 data bits -> no write strobe; rst_n low during RDATA driving 0 -> SDA 'z' immediately, all registers 0.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared IIC slave definitions: FSM state encoding, default bus address and R/W bit encoding.
package iic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    DEVACK,
    REGADDR,
    REGACK,
    WDATA,
    WDACK,
    RDATA,
    RDACK
  } iic_state_e;

  typedef enum logic {
    IIC_WRITE = 1'b0,
    IIC_READ  = 1'b1
  } iic_rw_e;

  localparam logic [6:0] IIC_DEFAULT_ADDR = 7'h50;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] slave_addr);
    return (addr_byte[7:1] == slave_addr);
  endfunction

endpackage

// File: rtl/iic_bus_sync.sv
// Two-flop synchronisers for SCL/SDA plus SCL edge and START/STOP detection,
// all derived from the synchronised samples so both lines share the same latency.
module iic_bus_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
  end

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/iic_slave.sv
// IIC register-file slave: byte FSM, shifter and REG_DEPTH x 8 register file.
// Define IIC_SLAVE_AUTOINC_EN to auto-increment the register pointer per data byte.
//
// state   | meaning
// IDLE    | bus ignored until a START
// DEVADDR | shifting in device address + R/W
// DEVACK  | driving ACK for a matched address
// REGADDR | shifting in register pointer
// REGACK  | driving ACK for the pointer byte
// WDATA   | shifting in a write byte
// WDACK   | driving ACK, write committed
// RDATA   | shifting out regfile[pointer]
// RDACK   | sampling master ACK/NACK
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = IIC_DEFAULT_ADDR,
  parameter int unsigned REG_DEPTH  = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       IICSCL,
  inout  wire        IICSDA,
  output logic       RegWrValid,
  output logic [7:0] RegWrAddr,
  output logic [7:0] RegWrData,
  output logic       Busy
);

`ifdef IIC_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  iic_bus_sync u_bus_sync (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .scl_in   (IICSCL),
    .sda_in   (IICSDA),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  iic_state_e state_q, state_d;
  iic_rw_e    rw_q, rw_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regs_q [REG_DEPTH];
  logic [7:0] regs_d [REG_DEPTH];

  logic [IDX_W-1:0] ptr_idx;
  logic [7:0]       rd_byte;
  logic             rx_state, rx_done;

  assign ptr_idx  = ptr_q[IDX_W-1:0];
  assign rd_byte  = regs_q[ptr_idx];
  assign rx_state = (state_q == DEVADDR) || (state_q == REGADDR) || (state_q == WDATA);
  assign rx_done  = scl_fall && (bit_cnt_q == 4'd8);

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = DEVADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      if (rx_state && scl_rise) begin
        shift_d   = {shift_q[6:0], sda};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      // Every SDA change below is taken on an SCL fall, so it lands while SCL is low.
      case (state_q)
        DEVADDR: begin
          if (rx_done) begin
            bit_cnt_d = '0;
            if (addr_match(shift_q, SLAVE_ADDR)) begin
              state_d  = DEVACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = iic_rw_e'(shift_q[0]);
            end else begin
              state_d  = IDLE;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        DEVACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q == IIC_READ) begin
              state_d  = RDATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = REGADDR;
              sda_oe_d = 1'b0;
            end
          end
        end
        REGADDR: begin
          if (rx_done) begin
            state_d   = REGACK;
            bit_cnt_d = '0;
            ptr_d     = shift_q;
            sda_oe_d  = 1'b1;
          end
        end
        REGACK, WDACK: begin
          if (scl_fall) begin
            state_d   = WDATA;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            if (AUTOINC && (state_q == WDACK)) ptr_d = ptr_q + 8'd1;
          end
        end
        WDATA: begin
          if (rx_done) begin
            state_d         = WDACK;
            bit_cnt_d       = '0;
            sda_oe_d        = 1'b1;
            regs_d[ptr_idx] = shift_q;
            wr_valid_d      = 1'b1;
            wr_addr_d       = ptr_q;
            wr_data_d       = shift_q;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              state_d  = RDACK;
              sda_oe_d = 1'b0;
              if (AUTOINC) ptr_d = ptr_q + 8'd1;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RDACK: begin
          // RDACK is entered on a fall, so the next fall always follows the ACK-bit rise.
          if (scl_rise && sda) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            state_d   = RDATA;
            bit_cnt_d = '0;
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rw_q       <= IIC_WRITE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      regs_q     <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign IICSDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign RegWrValid = wr_valid_q;
  assign RegWrAddr  = wr_addr_q;
  assign RegWrData  = wr_data_q;
  assign Busy       = busy_q;

endmodule
